// File: rtl/regbank_pair.sv
// Parametrised byte register bank with pair access, masked flag register,
// pair increment/decrement unit and sticky error. Define REGBANK_BYPASS_EN for same-cycle read-after-write.
module regbank_pair #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_REGS  = 12,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       FLAG_W    = 8,
  parameter logic [FLAG_W-1:0] FLAG_IMPL = 8'hF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          wr_mode,
  input  logic [ADDR_W-1:0]   wr_reg,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                idu_en,
  input  logic                idu_dec,
  input  logic [ADDR_W-1:0]   idu_reg,
  input  logic [ADDR_W-1:0]   rd_reg1,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data1_lo,
  input  logic [ADDR_W-1:0]   rd_reg2,
  output logic [DATA_W-1:0]   rd_data2,
  output logic [DATA_W-1:0]   rd_data2_lo,
  input  logic [FLAG_W-1:0]   flag_wr_mask,
  input  logic [FLAG_W-1:0]   flag_data,
  output logic [FLAG_W-1:0]   rd_flag,
  output logic                err
);

  localparam int unsigned       PAIR_W = 2 * DATA_W;
  localparam int unsigned       IDX_W  = ADDR_W + 1;
  localparam logic [IDX_W-1:0]  NREGS  = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0]  ONE    = IDX_W'(1);

  localparam logic [1:0] MODE_BYTE = 2'd1;
  localparam logic [1:0] MODE_PAIR = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] bank_t;

  bank_t             regs_q, regs_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              err_q, err_d;

  // Mux one byte out of a bank; indices past the last register read as zero.
  function automatic logic [DATA_W-1:0] pick(input bank_t bank, input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) v = bank[i];
    end
    return v;
  endfunction

  // Indices widened by one bit so that index+1 never wraps back into range.
  logic [IDX_W-1:0] wr_hi_idx, wr_lo_idx, idu_hi_idx, idu_lo_idx;
  assign wr_hi_idx  = {1'b0, wr_reg};
  assign wr_lo_idx  = wr_hi_idx + ONE;
  assign idu_hi_idx = {1'b0, idu_reg};
  assign idu_lo_idx = idu_hi_idx + ONE;

  logic wr_byte_ok, wr_pair_ok, wr_illegal;
  assign wr_byte_ok = (wr_mode == MODE_BYTE) && (wr_hi_idx < NREGS);
  assign wr_pair_ok = (wr_mode == MODE_PAIR) && !wr_reg[0] && (wr_lo_idx < NREGS);
  assign wr_illegal = ((wr_mode == MODE_BYTE) && !wr_byte_ok)
                   || ((wr_mode == MODE_PAIR) && !wr_pair_ok)
                   ||  (wr_mode == MODE_RSVD);

  logic idu_ok, idu_illegal, idu_overlap, idu_apply;
  assign idu_ok      = idu_en && !idu_reg[0] && (idu_lo_idx < NREGS);
  assign idu_illegal = idu_en && !idu_ok;

  // Any legal write landing on either IDU byte cancels the whole IDU update.
  assign idu_overlap = (wr_byte_ok && ((wr_hi_idx == idu_hi_idx) || (wr_hi_idx == idu_lo_idx)))
                    || (wr_pair_ok && ((wr_hi_idx == idu_hi_idx) || (wr_hi_idx == idu_lo_idx)
                                    || (wr_lo_idx == idu_hi_idx) || (wr_lo_idx == idu_lo_idx)));
  assign idu_apply   = idu_ok && !idu_overlap;

  logic [PAIR_W-1:0] idu_cur, idu_res;
  assign idu_cur = {pick(regs_q, idu_hi_idx), pick(regs_q, idu_lo_idx)};
  assign idu_res = idu_dec ? (idu_cur - PAIR_W'(1)) : (idu_cur + PAIR_W'(1));

  logic [FLAG_W-1:0] flag_mask;
  assign flag_mask = flag_wr_mask & FLAG_IMPL;

  // Next-state for the whole bank; reset is folded in so forwarding honours it too.
  always_comb begin
    regs_d  = regs_q;
    flags_d = ((flags_q & ~flag_mask) | (flag_data & flag_mask)) & FLAG_IMPL;
    err_d   = err_q | wr_illegal | idu_illegal;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idu_apply && (idu_hi_idx == IDX_W'(i))) regs_d[i] = idu_res[PAIR_W-1:DATA_W];
      if (idu_apply && (idu_lo_idx == IDX_W'(i))) regs_d[i] = idu_res[DATA_W-1:0];
      if (wr_byte_ok && (wr_hi_idx == IDX_W'(i))) regs_d[i] = wr_data[DATA_W-1:0];
      if (wr_pair_ok && (wr_hi_idx == IDX_W'(i))) regs_d[i] = wr_data[PAIR_W-1:DATA_W];
      if (wr_pair_ok && (wr_lo_idx == IDX_W'(i))) regs_d[i] = wr_data[DATA_W-1:0];
    end

    if (rst) begin
      regs_d  = '0;
      flags_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q  <= regs_d;
    flags_q <= flags_d;
    err_q   <= err_d;
  end

  bank_t rd_bank;
`ifdef REGBANK_BYPASS_EN
  assign rd_bank = regs_d;
  assign rd_flag = flags_d;
`else
  assign rd_bank = regs_q;
  assign rd_flag = flags_q;
`endif

  logic [IDX_W-1:0] rd1_idx, rd2_idx;
  assign rd1_idx = {1'b0, rd_reg1};
  assign rd2_idx = {1'b0, rd_reg2};

  assign rd_data1    = pick(rd_bank, rd1_idx);
  assign rd_data1_lo = pick(rd_bank, rd1_idx + ONE);
  assign rd_data2    = pick(rd_bank, rd2_idx);
  assign rd_data2_lo = pick(rd_bank, rd2_idx + ONE);
  assign err         = err_q;

endmodule

// File: tb/tb_regbank_pair.sv
// Directed self-checking bench for regbank_pair with hand-computed expectations.
module tb_regbank_pair;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FLAG_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          wr_mode = '0;
  logic [ADDR_W-1:0]   wr_reg = '0;
  logic [2*DATA_W-1:0] wr_data = '0;
  logic                idu_en = 1'b0;
  logic                idu_dec = 1'b0;
  logic [ADDR_W-1:0]   idu_reg = '0;
  logic [ADDR_W-1:0]   rd_reg1 = '0;
  logic [ADDR_W-1:0]   rd_reg2 = '0;
  logic [DATA_W-1:0]   rd_data1, rd_data1_lo, rd_data2, rd_data2_lo;
  logic [FLAG_W-1:0]   flag_wr_mask = '0;
  logic [FLAG_W-1:0]   flag_data = '0;
  logic [FLAG_W-1:0]   rd_flag;
  logic                err;

  int checks = 0;
  int errors = 0;

  regbank_pair dut (
    .clk(clk), .rst(rst),
    .wr_mode(wr_mode), .wr_reg(wr_reg), .wr_data(wr_data),
    .idu_en(idu_en), .idu_dec(idu_dec), .idu_reg(idu_reg),
    .rd_reg1(rd_reg1), .rd_data1(rd_data1), .rd_data1_lo(rd_data1_lo),
    .rd_reg2(rd_reg2), .rd_data2(rd_data2), .rd_data2_lo(rd_data2_lo),
    .flag_wr_mask(flag_wr_mask), .flag_data(flag_data), .rd_flag(rd_flag),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_mode      = 2'd0;
    idu_en       = 1'b0;
    idu_dec      = 1'b0;
    flag_wr_mask = '0;
    flag_data    = '0;
  endtask

  // Apply the currently driven request at the next edge, then go quiet.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pair_wr(input logic [ADDR_W-1:0] r, input logic [15:0] d);
    wr_mode = 2'd2; wr_reg = r; wr_data = d;
  endtask

  task automatic byte_wr(input logic [ADDR_W-1:0] r, input logic [7:0] d);
    wr_mode = 2'd1; wr_reg = r; wr_data = {8'h00, d};
  endtask

  task automatic idu(input logic [ADDR_W-1:0] r, input logic dec);
    idu_en = 1'b1; idu_reg = r; idu_dec = dec;
  endtask

  task automatic chk_pair(input string tag, input logic [ADDR_W-1:0] r, input logic [15:0] exp);
    rd_reg1 = r;
    #1;
    chk(tag, {16'h0, rd_data1, rd_data1_lo}, {16'h0, exp});
  endtask

  initial begin
    // Reset, then preload, then reset with a pair write pending
    tick();
    rst = 1'b0;
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_flag", 32'(rd_flag), 32'h0);
    chk_pair("rst_pair0", 4'd0, 16'h0000);

    pair_wr(4'd0, 16'h1234);
    flag_wr_mask = 8'hFF; flag_data = 8'hFF;
    tick();
    chk_pair("preload_pair0", 4'd0, 16'h1234);
    chk("preload_flag_impl", 32'(rd_flag), 32'hF0);

    rst = 1'b1;
    pair_wr(4'd2, 16'h5555);
    tick();
    rst = 1'b0;
    chk_pair("rst2_pair0", 4'd0, 16'h0000);
    chk_pair("rst2_pair2_ignored", 4'd2, 16'h0000);
    chk("rst2_flag", 32'(rd_flag), 32'h0);
    chk("rst2_err", 32'(err), 32'h0);

    // Pair write and both read ports
    pair_wr(4'd4, 16'hBEEF);
    tick();
    rd_reg1 = 4'd4; rd_reg2 = 4'd5;
    #1;
    chk("pw_rd1", 32'(rd_data1), 32'hBE);
    chk("pw_rd1_lo", 32'(rd_data1_lo), 32'hEF);
    chk("pw_rd2", 32'(rd_data2), 32'hEF);
    chk("pw_rd2_lo", 32'(rd_data2_lo), 32'h00);

    // IDU wrap in both directions, carry into high byte; flags left alone
    pair_wr(4'd6, 16'hFFFF);
    flag_wr_mask = 8'hFF; flag_data = 8'hA0;
    tick();
    chk_pair("idu_pre", 4'd6, 16'hFFFF);
    idu(4'd6, 1'b0);
    tick();
    chk_pair("idu_inc_wrap", 4'd6, 16'h0000);
    idu(4'd6, 1'b1);
    tick();
    chk_pair("idu_dec_wrap", 4'd6, 16'hFFFF);
    pair_wr(4'd6, 16'h00FF);
    tick();
    idu(4'd6, 1'b0);
    tick();
    chk_pair("idu_carry", 4'd6, 16'h0100);
    chk("idu_flags_kept", 32'(rd_flag), 32'hA0);
    chk("idu_err_clear", 32'(err), 32'h0);

    // Overlapping write cancels the IDU; a disjoint write does not
    pair_wr(4'd6, 16'h3456);
    tick();
    byte_wr(4'd7, 8'h12);
    idu(4'd6, 1'b0);
    tick();
    chk_pair("conflict_pair6", 4'd6, 16'h3412);
    byte_wr(4'd4, 8'h77);
    idu(4'd6, 1'b0);
    tick();
    chk_pair("disjoint_pair4", 4'd4, 16'h77EF);
    chk_pair("disjoint_pair6", 4'd6, 16'h3413);

    // Masked flag writes
    flag_wr_mask = 8'hFF; flag_data = 8'h00;
    tick();
    chk("flag_clear", 32'(rd_flag), 32'h00);
    flag_wr_mask = 8'h5F; flag_data = 8'hFF;
    tick();
    chk("flag_mask5f", 32'(rd_flag), 32'h50);
    flag_wr_mask = 8'h00; flag_data = 8'h00;
    tick();
    chk("flag_mask0", 32'(rd_flag), 32'h50);

    // Out-of-range reads return zero and never flag an error
    pair_wr(4'd10, 16'hCAFE);
    tick();
    byte_wr(4'd3, 8'hAB);
    tick();
    rd_reg1 = 4'd11; rd_reg2 = 4'd12;
    #1;
    chk("oor_rd1", 32'(rd_data1), 32'hFE);
    chk("oor_rd1_lo", 32'(rd_data1_lo), 32'h00);
    chk("oor_rd2", 32'(rd_data2), 32'h00);
    rd_reg2 = 4'd15;
    #1;
    chk("oor_rd2_15", 32'({rd_data2, rd_data2_lo}), 32'h0);
    chk("oor_no_err", 32'(err), 32'h0);

    // Odd pair write is dropped and sets sticky err
    pair_wr(4'd3, 16'h9999);
    tick();
    chk_pair("odd_pw_pair2", 4'd2, 16'h00AB);
    chk_pair("odd_pw_pair4", 4'd4, 16'h77EF);
    chk("odd_pw_err", 32'(err), 32'h1);
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    // Odd IDU index
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst3_err", 32'(err), 32'h0);
    idu(4'd5, 1'b0);
    tick();
    chk("odd_idu_err", 32'(err), 32'h1);
    chk_pair("odd_idu_pair4", 4'd4, 16'h0000);

    // Reserved mode
    rst = 1'b1; tick(); rst = 1'b0;
    wr_mode = 2'd3; wr_reg = 4'd0; wr_data = 16'hFFFF;
    tick();
    chk("rsvd_err", 32'(err), 32'h1);
    chk_pair("rsvd_pair0", 4'd0, 16'h0000);

    // Out-of-range byte write, and pair write whose low byte is out of range
    rst = 1'b1; tick(); rst = 1'b0;
    byte_wr(4'd12, 8'h11);
    tick();
    chk("oor_bw_err", 32'(err), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    pair_wr(4'd11, 16'h2222);
    tick();
    chk("oor_pw_err", 32'(err), 32'h1);
    chk_pair("oor_pw_pair10", 4'd10, 16'h0000);

    // Same-cycle read-after-write
    rst = 1'b1; tick(); rst = 1'b0;
    byte_wr(4'd2, 8'hA5);
    rd_reg1 = 4'd2;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("raw_same_cycle", 32'(rd_data1), 32'hA5);
`else
    chk("raw_same_cycle", 32'(rd_data1), 32'h00);
`endif
    tick();
    #1;
    chk("raw_next_cycle", 32'(rd_data1), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_pair.md
Name: regbank_pair

Overview:
- Parametrised CPU register bank. Successor to the fixed 8-bit, 11-entry register file.
- Provides byte registers that can also be accessed as high/low pairs, plus a flag register with a per-bit write mask.
- Adds an in-bank increment/decrement unit (IDU) for pair post-inc/dec, e.g. HL+, HL-, SP updates.
- Adds a sticky illegal-access error.
- Sits between the decode/execute stage and the ALU. Reads are combinational; all updates take effect on the clk edge.

Parameters:
- DATA_W, 8, width of one register.
- NUM_REGS, 12, number of byte registers; must be even.
- ADDR_W, 4, register index width; 2**ADDR_W >= NUM_REGS.
- FLAG_W, 8, flag register width.
- FLAG_IMPL, 8'hF0, implemented flag bits; unimplemented bits always read 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_mode  in  2  0 none, 1 byte write, 2 pair write, 3 reserved (treated as none and sets err)
- wr_reg  in  ADDR_W  write index; for pair writes, the high byte index
- wr_data  in  2*DATA_W  byte write uses [DATA_W-1:0]; pair write: high byte to wr_reg, low byte to wr_reg+1
- idu_en  in  1  request pair increment/decrement this cycle
- idu_dec  in  1  1 decrement, 0 increment
- idu_reg  in  ADDR_W  high index of pair to update
- rd_reg1  in  ADDR_W  read port 1 index
- rd_data1  out  DATA_W  regs[rd_reg1]
- rd_data1_lo  out  DATA_W  regs[rd_reg1+1]
- rd_reg2  in  ADDR_W  read port 2 index
- rd_data2  out  DATA_W  regs[rd_reg2]
- rd_data2_lo  out  DATA_W  regs[rd_reg2+1]
- flag_wr_mask  in  FLAG_W  per-bit flag write enable
- flag_data  in  FLAG_W  new flag values
- rd_flag  out  FLAG_W  current flags
- err  out  1  sticky illegal-access indicator

Behaviour:
- Reset: all regs 0, flags 0, err 0. rst overrides every write, IDU and flag request in the same cycle.
- Reads: combinational, zero latency.
  - Any read index >= NUM_REGS returns 0; this includes the _lo port when index+1 >= NUM_REGS.
  - Reads never set err.
- Byte write (wr_mode=1): regs[wr_reg] <= wr_data[DATA_W-1:0] at the clk edge.
- Pair write (wr_mode=2):
  - regs[wr_reg] <= wr_data[2*DATA_W-1:DATA_W] and regs[wr_reg+1] <= wr_data[DATA_W-1:0].
  - wr_reg must be even and wr_reg+1 < NUM_REGS.
- Illegal writes are dropped with no register changed, and set err on the next edge:
  - odd pair index;
  - out-of-range index;
  - wr_mode=3.
- IDU (idu_en=1):
  - The pair {regs[idu_reg], regs[idu_reg+1]} is treated as a 2*DATA_W unsigned value, updated to value+1 or value-1 modulo 2**(2*DATA_W).
  - Wrap-around: 16'hFFFF+1 gives 16'h0000; 16'h0000-1 gives 16'hFFFF.
  - Carry/borrow crosses from the low byte into the high byte.
  - Flags are never affected by the IDU.
  - Odd or out-of-range idu_reg: request dropped, err set.
- Simultaneous write and IDU in one cycle:
  - If the write touches either byte of the IDU pair, the explicit write wins for the bytes it writes.
  - The IDU result is then discarded entirely, including the untouched byte.
  - Non-overlapping write and IDU both take effect.
- Flags:
  - Next flags = (flags & ~mask) | (flag_data & mask), where mask = flag_wr_mask & FLAG_IMPL.
  - Unimplemented bits are held at 0.
  - A mask of 0 leaves flags unchanged.
- err: once set, held at 1 until rst.
- Without the optional feature, a read in the same cycle as a write to the same register returns the old value; the new value is visible from the next cycle.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: each read output and rd_flag is forwarded combinationally from the value being written this cycle, so same-cycle read-after-write returns the new value.
  - Forwarding covers byte, pair, IDU and masked-flag writes.
  - Forwarding follows the same priority rules as the register update.
  - Illegal writes are never forwarded.
- Undefined: reads return stored state only, one cycle after the write.

Test Plan:
- Reset: preload regs and flags, assert rst for 1 cycle -> all rd_data* = 0, rd_flag = 0, err = 0. A pair write issued during rst is ignored.
- Pair write and read: wr_mode=2, wr_reg=4, wr_data=16'hBEEF -> next cycle rd_reg1=4 gives rd_data1=8'hBE, rd_data1_lo=8'hEF. rd_reg2=5 gives rd_data2=8'hEF.
- IDU wrap:
  - pair 6 = 16'hFFFF, idu_en=1, idu_dec=0 -> 16'h0000;
  - then idu_dec=1 -> 16'hFFFF;
  - pair 6 = 16'h00FF increment -> 16'h0100;
  - flags unchanged throughout.
- Conflict: same cycle wr_mode=1, wr_reg=7, data 8'h12, with IDU increment of pair 6 = 16'h3456 -> regs[6]=8'h34, regs[7]=8'h12.
- Flags and illegal access:
  - flags=8'h00, flag_data=8'hFF, mask=8'h5F -> rd_flag=8'h50.
  - Then wr_mode=2, wr_reg=3 -> no register change; err=1 from the next cycle and held.
- Bypass (REGBANK_BYPASS_EN defined): byte write 8'hA5 to reg 2 with rd_reg1=2 in the same cycle -> rd_data1=8'hA5 in that cycle. Without the macro -> old value in that cycle, 8'hA5 in the next.
